d_latch_exerciser: RTL and testbench

Synchronous self-checking driver for a gated D latch. On `start` it drives a fixed 8-step (E, D) vector sequence into the latch's `D`/`E` inputs. It holds each step for a programmable settle window and samples `Q`/`Qbar`. Each sample is compared against an internal latch reference model, and the block reports error count, first failing step and pass/fail. It sits on the far side of the latch interface from the DUT and is used for on-chip or FPGA bring-up of the latch.

---
 rtl/d_latch_pkg.sv | 18 +
 rtl/d_latch_exerciser_ref.sv | 41 ++++
 rtl/d_latch_exerciser.sv | 156 +++++++++++++++
 tb/tb_d_latch_exerciser.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/d_latch_pkg.sv
// Shared types and constants for the gated D latch exerciser.
// The vector ROM is packed so that bit i holds step i.
package d_latch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 8;

  // Steps 7..0: E = 0,0,1,0,1,1,0,0  D = 1,0,1,1,0,1,1,0
  localparam logic [NUM_VEC-1:0] VEC_E = 8'b0010_1100;
  localparam logic [NUM_VEC-1:0] VEC_D = 8'b1011_0110;

endpackage

// File: rtl/d_latch_exerciser_ref.sv
// One-bit reference model of the gated latch. It tracks the expected Q and
// whether any enabled vector has been applied yet in this run.
module d_latch_ref (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic e,
  input  logic d,
  output logic exp_q,
  output logic exp_valid
);

  logic exp_q_q, exp_q_d;
  logic exp_valid_q, exp_valid_d;

  // clear and load may coincide on a run start; the loaded vector wins
  always_comb begin
    exp_q_d     = exp_q_q;
    exp_valid_d = exp_valid_q;
    if (clear) exp_valid_d = 1'b0;
    if (load && e) begin
      exp_q_d     = d;
      exp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_q     <= 1'b0;
      exp_valid_q <= 1'b0;
    end else begin
      exp_q_q     <= exp_q_d;
      exp_valid_q <= exp_valid_d;
    end
  end

  assign exp_q     = exp_q_q;
  assign exp_valid = exp_valid_q;

endmodule

// File: rtl/d_latch_exerciser.sv
// Drives the 8-step (E, D) sequence into a latch under test, samples Q/Qbar
// after HOLD_CYCLES and scores each enabled step against the reference model.
module d_latch_exerciser
  import d_latch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       D,
  output logic       E,
  input  logic       Q,
  input  logic       Qbar,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_idx,
  output logic       fail_seen,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             d_out_q, d_out_d;
  logic             e_out_q, e_out_d;
  logic             q_s_q, q_s_d;
  logic             qb_s_q, qb_s_d;
  logic [3:0]       err_count_q, err_count_d;
  logic [2:0]       fail_idx_q, fail_idx_d;
  logic             fail_seen_q, fail_seen_d;

  logic       ref_load, ref_clear;
  logic       exp_q, exp_valid;
  logic       step_fail;
  logic [2:0] idx_next;

  d_latch_ref u_ref (
    .clk       (clk),
    .rst       (rst),
    .load      (ref_load),
    .clear     (ref_clear),
    .e         (e_out_d),
    .d         (d_out_d),
    .exp_q     (exp_q),
    .exp_valid (exp_valid)
  );

  // A broken complementary output counts as a failure even when Q is right
  assign step_fail = exp_valid && ((q_s_q != exp_q) || (qb_s_q == q_s_q));
  assign idx_next  = idx_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_cnt_d  = hold_cnt_q;
    d_out_d     = d_out_q;
    e_out_d     = e_out_q;
    q_s_d       = q_s_q;
    qb_s_d      = qb_s_q;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;
    fail_seen_d = fail_seen_q;
    ref_load    = 1'b0;
    ref_clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          idx_d       = 3'd0;
          hold_cnt_d  = '0;
          d_out_d     = VEC_D[0];
          e_out_d     = VEC_E[0];
          ref_load    = 1'b1;
          ref_clear   = 1'b1;
          err_count_d = 4'd0;
          fail_idx_d  = 3'd0;
          fail_seen_d = 1'b0;
        end
      end
      SETTLE: begin
        if (hold_cnt_q == CNT_LAST) begin
          q_s_d      = Q;
          qb_s_d     = Qbar;
          hold_cnt_d = '0;
          state_d    = CHECK;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (step_fail) begin
          err_count_d = err_count_q + 4'd1;
          if (!fail_seen_q) begin
            fail_idx_d  = idx_q;
            fail_seen_d = 1'b1;
          end
        end
        if (idx_q == 3'(NUM_VEC - 1)) begin
          state_d = DONE;
          d_out_d = 1'b0;
          e_out_d = 1'b0;
        end else begin
          idx_d    = idx_next;
          d_out_d  = VEC_D[idx_next];
          e_out_d  = VEC_E[idx_next];
          ref_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      hold_cnt_q  <= '0;
      d_out_q     <= 1'b0;
      e_out_q     <= 1'b0;
      q_s_q       <= 1'b0;
      qb_s_q      <= 1'b0;
      err_count_q <= 4'd0;
      fail_idx_q  <= 3'd0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_cnt_q  <= hold_cnt_d;
      d_out_q     <= d_out_d;
      e_out_q     <= e_out_d;
      q_s_q       <= q_s_d;
      qb_s_q      <= qb_s_d;
      err_count_q <= err_count_d;
      fail_idx_q  <= fail_idx_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign D         = d_out_q;
  assign E         = e_out_q;
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count_q == 4'd0);
  assign err_count = err_count_q;
  assign fail_idx  = fail_idx_q;
  assign fail_seen = fail_seen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_d_latch_exerciser.sv
// Directed bench: two exercisers (HOLD_CYCLES 4 and 1), each driving a
// behavioural latch with selectable faults on its Q/Qbar path.
module tb_d_latch_exerciser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: HOLD_CYCLES=4
  logic       start0 = 1'b0;
  logic       d0, e0, q0, qb0, busy0, done0, pass0, fs0;
  logic [3:0] ec0;
  logic [2:0] fi0;
  logic [1:0] st0;
  logic       lq0 = 1'b0;
  int         fault0 = 0;

  // instance 1: HOLD_CYCLES=1
  logic       start1 = 1'b0;
  logic       d1, e1, q1, qb1, busy1, done1, pass1, fs1;
  logic [3:0] ec1;
  logic [2:0] fi1;
  logic [1:0] st1;
  logic       lq1 = 1'b0;

  d_latch_exerciser #(.HOLD_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .D(d0), .E(e0), .Q(q0), .Qbar(qb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .fail_idx(fi0), .fail_seen(fs0), .dbg_state(st0)
  );

  d_latch_exerciser #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .D(d1), .E(e1), .Q(q1), .Qbar(qb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .fail_idx(fi1), .fail_seen(fs1), .dbg_state(st1)
  );

  // fault0: 0 = good latch, 1 = Q stuck at 0, 2 = Qbar tied to Q
  always @(e0, d0) if (e0) lq0 = d0;
  always @(e1, d1) if (e1) lq1 = d1;
  assign q0  = (fault0 == 1) ? 1'b0 : lq0;
  assign qb0 = (fault0 == 2) ? q0 : ~q0;
  assign q1  = lq1;
  assign qb1 = ~q1;

  bit tb_e [8] = '{0, 0, 1, 1, 0, 1, 0, 0};
  bit tb_d [8] = '{0, 1, 1, 0, 1, 1, 0, 1};

  int n_vec = 0;
  int n_err = 0;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a run and counts cycles from the start edge until done.
  task automatic run(input int sel, input int budget, input int pulse_at,
                     input int stop_at, input bit chk_vec, output int cnt);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    cnt = 0;
    chk("start_done_low", {7'd0, (sel == 0) ? done0 : done1}, 8'd0);
    chk("start_busy",     {7'd0, (sel == 0) ? busy0 : busy1}, 8'd1);
    if (chk_vec) chk("vec0", {6'd0, e0, d0}, {6'd0, tb_e[0], tb_d[0]});
    while (!((sel == 0) ? done0 : done1) && cnt < budget && cnt != stop_at) begin
      tick();
      cnt++;
      if (sel == 0) start0 = (cnt == pulse_at);
      if (chk_vec && (cnt % 5 == 0) && cnt < 40)
        chk($sformatf("vec%0d", cnt / 5), {6'd0, e0, d0},
            {6'd0, tb_e[cnt / 5], tb_d[cnt / 5]});
    end
    start0 = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_de",    {6'd0, e0, d0}, 8'd0);
    chk("rst_busy",  {7'd0, busy0}, 8'd0);
    chk("rst_done",  {6'd0, done0, pass0}, 8'd0);
    chk("rst_err",   {4'd0, ec0}, 8'd0);
    chk("rst_fail",  {4'd0, fs0, fi0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // good latch, default hold
    run(0, 100, -1, -1, 1'b1, n);
    chk("good_cycles", 8'(n), 8'd40);
    chk("good_pass",   {6'd0, done0, pass0}, 8'b11);
    chk("good_err",    {4'd0, ec0}, 8'd0);
    chk("good_seen",   {7'd0, fs0}, 8'd0);
    chk("good_idle_de", {5'd0, busy0, e0, d0}, 8'd0);

    // Q stuck at 0: steps 2,5,6,7 fail
    fault0 = 1;
    run(0, 100, -1, -1, 1'b0, n);
    chk("stuck_cycles", 8'(n), 8'd40);
    chk("stuck_err",    {4'd0, ec0}, 8'd4);
    chk("stuck_fail",   {4'd0, fs0, fi0}, {4'd0, 1'b1, 3'd2});
    chk("stuck_pass",   {6'd0, done0, pass0}, 8'b10);

    // Qbar tied to Q: every checked step fails
    fault0 = 2;
    run(0, 100, -1, -1, 1'b0, n);
    chk("qbar_err",  {4'd0, ec0}, 8'd6);
    chk("qbar_fail", {4'd0, fs0, fi0}, {4'd0, 1'b1, 3'd2});
    chk("qbar_pass", {7'd0, pass0}, 8'd0);

    // start pulsed during SETTLE of step 3 is ignored
    fault0 = 0;
    run(0, 100, 16, -1, 1'b0, n);
    chk("pulse_cycles", 8'(n), 8'd40);
    chk("pulse_pass",   {6'd0, done0, pass0}, 8'b11);

    // asynchronous reset in the middle of step 5
    fault0 = 1;
    run(0, 100, -1, 27, 1'b0, n);
    chk("mid_de",   {6'd0, e0, d0}, 8'b11);
    chk("mid_busy", {7'd0, busy0}, 8'd1);
    chk("mid_err",  {4'd0, ec0}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_de",   {6'd0, e0, d0}, 8'd0);
    chk("arst_busy", {6'd0, busy0, done0}, 8'd0);
    chk("arst_err",  {4'd0, ec0}, 8'd0);
    chk("arst_fail", {4'd0, fs0, fi0}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    fault0 = 0;
    tick();
    run(0, 100, -1, -1, 1'b0, n);
    chk("post_cycles", 8'(n), 8'd40);
    chk("post_pass",   {6'd0, done0, pass0}, 8'b11);

    // HOLD_CYCLES=1, then restart straight from DONE
    run(1, 60, -1, -1, 1'b0, n);
    chk("h1_cycles", 8'(n), 8'd16);
    chk("h1_pass",   {6'd0, done1, pass1}, 8'b11);
    chk("h1_err",    {4'd0, ec1}, 8'd0);
    run(1, 60, -1, -1, 1'b0, n);
    chk("h1_rerun_cycles", 8'(n), 8'd16);
    chk("h1_rerun_pass",   {6'd0, done1, pass1}, 8'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
